// File: rtl/rpc_app_ctrl_multi.sv
// Per-flow control FSM for the RPC server app tile: dequeue, fetch pointers,
// read the header, then echo or sink the payload, update pointers and requeue.
module rpc_app_ctrl_multi #(
  parameter int unsigned HDR_BEATS = 1,
  parameter int unsigned CNT_W     = 32,
  localparam int unsigned HDR_IDX_W = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_sink_mode,
  input  logic                 flow_fifo_ctrl_flowid_val,
  output logic                 ctrl_flow_fifo_flowid_yumi,
  output logic                 ctrl_requeue_flow_val,
  input  logic                 flow_fifo_ctrl_enqueue_rdy,
  output logic                 app_rx_head_ptr_rd_req_val,
  input  logic                 app_rx_head_ptr_rd_req_rdy,
  output logic                 app_rx_commit_ptr_rd_req_val,
  input  logic                 app_rx_commit_ptr_rd_req_rdy,
  input  logic                 rx_head_ptr_app_rd_resp_val,
  output logic                 rx_head_ptr_app_rd_resp_rdy,
  input  logic                 rx_commit_ptr_app_rd_resp_val,
  output logic                 rx_commit_ptr_app_rd_resp_rdy,
  output logic                 app_head_ptr_tx_rd_req0_val,
  input  logic                 app_head_ptr_tx_rd_req0_rdy,
  output logic                 app_tail_ptr_tx_rd_req1_val,
  input  logic                 app_tail_ptr_tx_rd_req1_rdy,
  input  logic                 head_ptr_app_tx_rd_resp0_val,
  output logic                 head_ptr_app_tx_rd_resp0_rdy,
  input  logic                 tail_ptr_app_tx_rd_resp1_val,
  output logic                 tail_ptr_app_tx_rd_resp1_rdy,
  output logic                 app_rx_head_ptr_wr_req_val,
  input  logic                 rx_head_ptr_app_wr_req_rdy,
  output logic                 app_tail_ptr_tx_wr_req_val,
  input  logic                 tail_ptr_app_tx_wr_req_rdy,
  output logic                 ctrl_rd_buf_req_val,
  input  logic                 rd_buf_ctrl_req_rdy,
  input  logic                 rd_buf_ctrl_resp_data_val,
  output logic                 ctrl_rd_buf_resp_data_rdy,
  output logic                 ctrl_wr_buf_req_val,
  input  logic                 wr_buf_ctrl_req_rdy,
  output logic                 ctrl_wr_buf_req_data_val,
  input  logic                 wr_buf_ctrl_req_data_rdy,
  input  logic                 wr_buf_ctrl_req_done,
  output logic                 ctrl_wr_buf_done_rdy,
  input  logic                 datap_ctrl_hdr_arrived,
  input  logic                 datap_ctrl_rd_sat,
  input  logic                 datap_ctrl_wr_sat,
  input  logic                 datap_ctrl_last_wr,
  output logic                 store_curr_flowid,
  output logic                 store_rx_ptrs,
  output logic                 store_tx_ptrs,
  output logic                 store_req_hdr,
  output logic                 ctrl_datap_decr_bytes_left,
  output logic [HDR_IDX_W-1:0] ctrl_datap_hdr_beat_idx,
  output logic                 ctrl_datap_sink_mode,
  output logic [CNT_W-1:0]     perf_flows_served,
  output logic [CNT_W-1:0]     perf_no_progress
);

  localparam logic [HDR_IDX_W-1:0] LAST_BEAT = HDR_IDX_W'(HDR_BEATS - 1);

  typedef enum logic [3:0] {
    READY, RX_PTRS_REQ, RX_PTRS_RESP, RD_REQ_HDR, WAIT_REQ_HDR, SINK_CHECK,
    TX_PTRS_REQ, TX_PTRS_RESP, CHECK_WR_DATA, TX_WR_MEM_REQ, PAYLOAD_COPY,
    WAIT_WR_RESP, ADJUST_RX_HEAD, ADJUST_TX_TAIL, REQUEUE
  } state_t;

  state_t               state, state_nxt;
  logic [HDR_IDX_W-1:0] beat_cnt;
  logic                 mode_reg;
  logic                 cnt_clr, cnt_inc, served_evt, np_evt;
  logic                 rx_resp_pair, tx_resp_pair;

  // Both halves of a pointer response pair are accepted together.
  assign rx_resp_pair = rx_head_ptr_app_rd_resp_val & rx_commit_ptr_app_rd_resp_val;
  assign tx_resp_pair = head_ptr_app_tx_rd_resp0_val & tail_ptr_app_tx_rd_resp1_val;
  assign ctrl_datap_sink_mode = mode_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= READY;
      beat_cnt          <= '0;
      mode_reg          <= 1'b0;
      perf_flows_served <= '0;
      perf_no_progress  <= '0;
    end else begin
      state <= state_nxt;
      if (store_curr_flowid) mode_reg <= cfg_sink_mode;
      if (cnt_clr)      beat_cnt <= '0;
      else if (cnt_inc) beat_cnt <= beat_cnt + HDR_IDX_W'(1);
      if (served_evt && (perf_flows_served != '1))
        perf_flows_served <= perf_flows_served + CNT_W'(1);
      if (np_evt && (perf_no_progress != '1))
        perf_no_progress <= perf_no_progress + CNT_W'(1);
    end
  end

  // Next state, handshakes and datapath strobes; everything idles while in reset.
  always_comb begin
    state_nxt                     = state;
    cnt_clr                       = 1'b0;
    cnt_inc                       = 1'b0;
    served_evt                    = 1'b0;
    np_evt                        = 1'b0;
    ctrl_flow_fifo_flowid_yumi    = 1'b0;
    ctrl_requeue_flow_val         = 1'b0;
    app_rx_head_ptr_rd_req_val    = 1'b0;
    app_rx_commit_ptr_rd_req_val  = 1'b0;
    rx_head_ptr_app_rd_resp_rdy   = 1'b0;
    rx_commit_ptr_app_rd_resp_rdy = 1'b0;
    app_head_ptr_tx_rd_req0_val   = 1'b0;
    app_tail_ptr_tx_rd_req1_val   = 1'b0;
    head_ptr_app_tx_rd_resp0_rdy  = 1'b0;
    tail_ptr_app_tx_rd_resp1_rdy  = 1'b0;
    app_rx_head_ptr_wr_req_val    = 1'b0;
    app_tail_ptr_tx_wr_req_val    = 1'b0;
    ctrl_rd_buf_req_val           = 1'b0;
    ctrl_rd_buf_resp_data_rdy     = 1'b0;
    ctrl_wr_buf_req_val           = 1'b0;
    ctrl_wr_buf_req_data_val      = 1'b0;
    ctrl_wr_buf_done_rdy          = 1'b0;
    store_curr_flowid             = 1'b0;
    store_rx_ptrs                 = 1'b0;
    store_tx_ptrs                 = 1'b0;
    store_req_hdr                 = 1'b0;
    ctrl_datap_decr_bytes_left    = 1'b0;
    ctrl_datap_hdr_beat_idx       = '0;
    if (!rst) begin
      unique case (state)
        READY: if (flow_fifo_ctrl_flowid_val) begin
          ctrl_flow_fifo_flowid_yumi = 1'b1;
          store_curr_flowid          = 1'b1;
          state_nxt                  = RX_PTRS_REQ;
        end
        RX_PTRS_REQ: begin
          app_rx_head_ptr_rd_req_val   = 1'b1;
          app_rx_commit_ptr_rd_req_val = 1'b1;
          if (app_rx_head_ptr_rd_req_rdy && app_rx_commit_ptr_rd_req_rdy) state_nxt = RX_PTRS_RESP;
        end
        RX_PTRS_RESP: if (rx_resp_pair) begin
          rx_head_ptr_app_rd_resp_rdy   = 1'b1;
          rx_commit_ptr_app_rd_resp_rdy = 1'b1;
          store_rx_ptrs                 = 1'b1;
          state_nxt                     = RD_REQ_HDR;
        end
        RD_REQ_HDR: begin
          if (!datap_ctrl_hdr_arrived) begin
            np_evt    = 1'b1;
            state_nxt = REQUEUE;
          end else begin
            ctrl_rd_buf_req_val = 1'b1;
            if (rd_buf_ctrl_req_rdy) begin
              cnt_clr   = 1'b1;
              state_nxt = WAIT_REQ_HDR;
            end
          end
        end
        WAIT_REQ_HDR: begin
          ctrl_rd_buf_resp_data_rdy = 1'b1;
          ctrl_datap_hdr_beat_idx   = beat_cnt;
          if (rd_buf_ctrl_resp_data_val) begin
            store_req_hdr = 1'b1;
            if (beat_cnt == LAST_BEAT) state_nxt = mode_reg ? SINK_CHECK : TX_PTRS_REQ;
            else                       cnt_inc   = 1'b1;
          end
        end
        SINK_CHECK: begin
          if (datap_ctrl_rd_sat) state_nxt = ADJUST_RX_HEAD;
          else begin
            np_evt    = 1'b1;
            state_nxt = REQUEUE;
          end
        end
        TX_PTRS_REQ: begin
          app_head_ptr_tx_rd_req0_val = 1'b1;
          app_tail_ptr_tx_rd_req1_val = 1'b1;
          if (!datap_ctrl_rd_sat) begin
            np_evt    = 1'b1;
            state_nxt = REQUEUE;
          end else if (app_head_ptr_tx_rd_req0_rdy && app_tail_ptr_tx_rd_req1_rdy) begin
            state_nxt = TX_PTRS_RESP;
          end
        end
        TX_PTRS_RESP: if (tx_resp_pair) begin
          head_ptr_app_tx_rd_resp0_rdy = 1'b1;
          tail_ptr_app_tx_rd_resp1_rdy = 1'b1;
          store_tx_ptrs                = 1'b1;
          state_nxt                    = CHECK_WR_DATA;
        end
        CHECK_WR_DATA: begin
          if (datap_ctrl_wr_sat) state_nxt = TX_WR_MEM_REQ;
          else begin
            np_evt    = 1'b1;
            state_nxt = REQUEUE;
          end
        end
        TX_WR_MEM_REQ: begin
          ctrl_wr_buf_req_val = 1'b1;
          if (wr_buf_ctrl_req_rdy) state_nxt = PAYLOAD_COPY;
        end
        PAYLOAD_COPY: begin
          ctrl_wr_buf_req_data_val = 1'b1;
          if (wr_buf_ctrl_req_data_rdy) begin
            ctrl_datap_decr_bytes_left = 1'b1;
            if (datap_ctrl_last_wr) state_nxt = WAIT_WR_RESP;
          end
        end
        WAIT_WR_RESP: begin
          ctrl_wr_buf_done_rdy = 1'b1;
          if (wr_buf_ctrl_req_done) state_nxt = ADJUST_RX_HEAD;
        end
        ADJUST_RX_HEAD: begin
          app_rx_head_ptr_wr_req_val = 1'b1;
          if (rx_head_ptr_app_wr_req_rdy) begin
            served_evt = 1'b1;
            state_nxt  = mode_reg ? REQUEUE : ADJUST_TX_TAIL;
          end
        end
        ADJUST_TX_TAIL: begin
          app_tail_ptr_tx_wr_req_val = 1'b1;
          if (tail_ptr_app_tx_wr_req_rdy) state_nxt = REQUEUE;
        end
        REQUEUE: begin
          ctrl_requeue_flow_val = 1'b1;
          if (flow_fifo_ctrl_enqueue_rdy) state_nxt = READY;
        end
        default: state_nxt = READY;
      endcase
    end
  end

endmodule

// File: tb/tb_rpc_app_ctrl_multi.sv
// Directed plus randomized flow visits for rpc_app_ctrl_multi, checked against
// a per-flow outcome model (expected strobe/handshake counts and saturating counters).
module tb_rpc_app_ctrl_multi;

  localparam int unsigned HDR   = 4;
  localparam int unsigned CW    = 4;
  localparam int          SATV  = (1 << CW) - 1;
  localparam int          C_RXRD = 0, C_RDBUF = 1, C_TXRD = 2, C_WRREQ = 3,
                          C_DATA = 4, C_RXWR = 5, C_TXWR = 6, C_RQ = 7;

  logic clk = 1'b0, rst;
  logic cfg_sink_mode, flowid_val, yumi, requeue_val, enqueue_rdy;
  logic rx_h_rd_val, rx_h_rd_rdy, rx_c_rd_val, rx_c_rd_rdy;
  logic rx_h_resp_val, rx_h_resp_rdy, rx_c_resp_val, rx_c_resp_rdy;
  logic tx_h_rd_val, tx_h_rd_rdy, tx_t_rd_val, tx_t_rd_rdy;
  logic tx_h_resp_val, tx_h_resp_rdy, tx_t_resp_val, tx_t_resp_rdy;
  logic rx_wr_val, rx_wr_rdy, tx_wr_val, tx_wr_rdy;
  logic rd_req_val, rd_req_rdy, rd_data_val, rd_data_rdy;
  logic wr_req_val, wr_req_rdy, wr_data_val, wr_data_rdy, wr_done, wr_done_rdy;
  logic hdr_arrived, rd_sat, wr_sat, last_wr;
  logic st_flowid, st_rx, st_tx, st_hdr, decr, sink_out;
  logic [1:0]    hdr_idx;
  logic [CW-1:0] perf_served, perf_np;
  logic          any_out;

  int compared = 0, mismatched = 0;
  int served_ev = 0, np_ev = 0;
  int mon [10];

  always #5 clk = ~clk;

  rpc_app_ctrl_multi #(.HDR_BEATS(HDR), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_sink_mode(cfg_sink_mode),
    .flow_fifo_ctrl_flowid_val(flowid_val), .ctrl_flow_fifo_flowid_yumi(yumi),
    .ctrl_requeue_flow_val(requeue_val), .flow_fifo_ctrl_enqueue_rdy(enqueue_rdy),
    .app_rx_head_ptr_rd_req_val(rx_h_rd_val), .app_rx_head_ptr_rd_req_rdy(rx_h_rd_rdy),
    .app_rx_commit_ptr_rd_req_val(rx_c_rd_val), .app_rx_commit_ptr_rd_req_rdy(rx_c_rd_rdy),
    .rx_head_ptr_app_rd_resp_val(rx_h_resp_val), .rx_head_ptr_app_rd_resp_rdy(rx_h_resp_rdy),
    .rx_commit_ptr_app_rd_resp_val(rx_c_resp_val), .rx_commit_ptr_app_rd_resp_rdy(rx_c_resp_rdy),
    .app_head_ptr_tx_rd_req0_val(tx_h_rd_val), .app_head_ptr_tx_rd_req0_rdy(tx_h_rd_rdy),
    .app_tail_ptr_tx_rd_req1_val(tx_t_rd_val), .app_tail_ptr_tx_rd_req1_rdy(tx_t_rd_rdy),
    .head_ptr_app_tx_rd_resp0_val(tx_h_resp_val), .head_ptr_app_tx_rd_resp0_rdy(tx_h_resp_rdy),
    .tail_ptr_app_tx_rd_resp1_val(tx_t_resp_val), .tail_ptr_app_tx_rd_resp1_rdy(tx_t_resp_rdy),
    .app_rx_head_ptr_wr_req_val(rx_wr_val), .rx_head_ptr_app_wr_req_rdy(rx_wr_rdy),
    .app_tail_ptr_tx_wr_req_val(tx_wr_val), .tail_ptr_app_tx_wr_req_rdy(tx_wr_rdy),
    .ctrl_rd_buf_req_val(rd_req_val), .rd_buf_ctrl_req_rdy(rd_req_rdy),
    .rd_buf_ctrl_resp_data_val(rd_data_val), .ctrl_rd_buf_resp_data_rdy(rd_data_rdy),
    .ctrl_wr_buf_req_val(wr_req_val), .wr_buf_ctrl_req_rdy(wr_req_rdy),
    .ctrl_wr_buf_req_data_val(wr_data_val), .wr_buf_ctrl_req_data_rdy(wr_data_rdy),
    .wr_buf_ctrl_req_done(wr_done), .ctrl_wr_buf_done_rdy(wr_done_rdy),
    .datap_ctrl_hdr_arrived(hdr_arrived), .datap_ctrl_rd_sat(rd_sat),
    .datap_ctrl_wr_sat(wr_sat), .datap_ctrl_last_wr(last_wr),
    .store_curr_flowid(st_flowid), .store_rx_ptrs(st_rx), .store_tx_ptrs(st_tx),
    .store_req_hdr(st_hdr), .ctrl_datap_decr_bytes_left(decr),
    .ctrl_datap_hdr_beat_idx(hdr_idx), .ctrl_datap_sink_mode(sink_out),
    .perf_flows_served(perf_served), .perf_no_progress(perf_np)
  );

  assign any_out = |{yumi, requeue_val, rx_h_rd_val, rx_c_rd_val, rx_h_resp_rdy, rx_c_resp_rdy,
                     tx_h_rd_val, tx_t_rd_val, tx_h_resp_rdy, tx_t_resp_rdy, rx_wr_val, tx_wr_val,
                     rd_req_val, rd_data_rdy, wr_req_val, wr_data_val, wr_done_rdy,
                     st_flowid, st_rx, st_tx, st_hdr, decr};

  // Event counters: header stores, TX reads, wr_buf reqs, decr, RX/TX writes, requeues.
  always @(posedge clk) begin
    if (!rst) begin
      if (st_hdr) mon[0] <= mon[0] + 1;
      if (tx_h_rd_val && tx_h_rd_rdy && tx_t_rd_val && tx_t_rd_rdy) mon[1] <= mon[1] + 1;
      if (wr_req_val && wr_req_rdy) mon[2] <= mon[2] + 1;
      if (decr) mon[3] <= mon[3] + 1;
      if (rx_wr_val && rx_wr_rdy) mon[4] <= mon[4] + 1;
      if (tx_wr_val && tx_wr_rdy) mon[5] <= mon[5] + 1;
      if (requeue_val && enqueue_rdy) mon[6] <= mon[6] + 1;
      if (st_rx) mon[7] <= mon[7] + 1;
      if (st_tx) mon[8] <= mon[8] + 1;
      if (yumi) mon[9] <= mon[9] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > SATV) ? 32'(SATV) : 32'(n);
  endfunction

  function automatic logic oval(input int ch);
    case (ch)
      C_RXRD:  return rx_h_rd_val & rx_c_rd_val;
      C_RDBUF: return rd_req_val;
      C_TXRD:  return tx_h_rd_val & tx_t_rd_val;
      C_WRREQ: return wr_req_val;
      C_DATA:  return wr_data_val;
      C_RXWR:  return rx_wr_val;
      C_TXWR:  return tx_wr_val;
      default: return requeue_val;
    endcase
  endfunction

  task automatic set_rdy(input int ch, input logic v);
    case (ch)
      C_RXRD:  begin rx_h_rd_rdy = v; rx_c_rd_rdy = v; end
      C_RDBUF: rd_req_rdy = v;
      C_TXRD:  begin tx_h_rd_rdy = v; tx_t_rd_rdy = v; end
      C_WRREQ: wr_req_rdy = v;
      C_DATA:  wr_data_rdy = v;
      C_RXWR:  rx_wr_rdy = v;
      C_TXWR:  tx_wr_rdy = v;
      default: enqueue_rdy = v;
    endcase
  endtask

  task automatic wait_val(input int ch, input string tag);
    int t = 0;
    while (!oval(ch) && t < 40) begin @(negedge clk); #1; t++; end
    chk({tag, "_val"}, 32'(oval(ch)), 32'd1);
  endtask

  // Valid/ready handshake with bp cycles of backpressure; val must hold meanwhile.
  task automatic hs(input int ch, input int bp, input string tag);
    wait_val(ch, tag);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk); #1;
      chk({tag, "_hold"}, 32'(oval(ch)), 32'd1);
    end
    set_rdy(ch, 1'b1); #1;
    if (ch == C_DATA) chk("decr", 32'(decr), 32'd1);
    @(negedge clk); set_rdy(ch, 1'b0); #1;
  endtask

  task automatic resp(input logic tx, input int dly, input string tag);
    repeat (dly) @(negedge clk);
    if (tx) begin tx_h_resp_val = 1'b1; tx_t_resp_val = 1'b1; end
    else    begin rx_h_resp_val = 1'b1; rx_c_resp_val = 1'b1; end
    #1;
    if (tx) chk({tag, "_rdy"}, 32'(tx_h_resp_rdy & tx_t_resp_rdy), 32'd1);
    else    chk({tag, "_rdy"}, 32'(rx_h_resp_rdy & rx_c_resp_rdy), 32'd1);
    chk({tag, "_store"}, 32'(tx ? st_tx : st_rx), 32'd1);
    @(negedge clk);
    rx_h_resp_val = 1'b0; rx_c_resp_val = 1'b0; tx_h_resp_val = 1'b0; tx_t_resp_val = 1'b0;
    #1;
  endtask

  // One complete flow visit; the expected path follows from the mode and status bits.
  task automatic run_flow(input logic sink, input logic hdr, input logic rs, input logic ws,
                          input int n, input int bp, input logic do_rst);
    int base [10];
    int ex [7];
    logic tx_path, wr_path, prog;
    base    = mon;
    tx_path = !sink && hdr && rs;
    wr_path = tx_path && ws;
    prog    = hdr && rs && (sink || ws);
    hdr_arrived = hdr; rd_sat = rs; wr_sat = ws; last_wr = 1'b0;
    cfg_sink_mode = sink; flowid_val = 1'b1; #1;
    chk("yumi", 32'(yumi), 32'd1);
    chk("store_flowid", 32'(st_flowid), 32'd1);
    @(negedge clk); flowid_val = 1'b0; cfg_sink_mode = ~sink; #1;
    chk("mode_latched", 32'(sink_out), 32'(sink));
    hs(C_RXRD, bp, "rx_rd");
    resp(1'b0, bp, "rx_resp");
    if (hdr) begin
      hs(C_RDBUF, bp, "rd_buf");
      for (int b = 0; b < int'(HDR); b++) begin
        repeat (bp) @(negedge clk);
        rd_data_val = 1'b1; #1;
        chk("hdr_rdy", 32'(rd_data_rdy), 32'd1);
        chk("hdr_idx", 32'(hdr_idx), 32'(b));
        @(negedge clk); rd_data_val = 1'b0; #1;
      end
    end
    if (tx_path) begin
      hs(C_TXRD, bp, "tx_rd");
      resp(1'b1, bp, "tx_resp");
      if (ws) begin
        hs(C_WRREQ, bp, "wr_req");
        if (do_rst) begin
          wait_val(C_DATA, "data_pre_rst");
          rst = 1'b1; #1;
          chk("rst_outputs", 32'(any_out), 32'd0);
          @(negedge clk); rst = 1'b0;
          hdr_arrived = 1'b0; rd_sat = 1'b0; wr_sat = 1'b0; #1;
          chk("post_rst_idle", 32'(any_out), 32'd0);
          chk("post_rst_served", 32'(perf_served), 32'd0);
          chk("post_rst_np", 32'(perf_np), 32'd0);
          served_ev = 0; np_ev = 0;
          return;
        end
        for (int i = 0; i < n; i++) begin
          last_wr = (i == n - 1);
          hs(C_DATA, bp, "data");
        end
        last_wr = 1'b0;
        repeat (bp) @(negedge clk);
        wr_done = 1'b1; #1;
        chk("done_rdy", 32'(wr_done_rdy), 32'd1);
        @(negedge clk); wr_done = 1'b0; #1;
      end
    end
    if (prog) begin
      hs(C_RXWR, bp, "rx_wr");
      served_ev++;
      if (!sink) hs(C_TXWR, bp, "tx_wr");
    end else begin
      np_ev++;
    end
    hs(C_RQ, bp, "requeue");
    ex[0] = hdr ? int'(HDR) : 0;
    ex[1] = int'(tx_path);
    ex[2] = int'(wr_path);
    ex[3] = wr_path ? n : 0;
    ex[4] = int'(prog);
    ex[5] = int'(prog && !sink);
    ex[6] = 1;
    for (int k = 0; k < 7; k++)
      chk($sformatf("count%0d", k), 32'(mon[k] - base[k]), 32'(ex[k]));
    chk("perf_served", 32'(perf_served), sat(served_ev));
    chk("perf_np", 32'(perf_np), sat(np_ev));
    chk("idle_after", 32'(any_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_sink_mode = 1'b0; flowid_val = 1'b0; enqueue_rdy = 1'b0;
    rx_h_rd_rdy = 1'b0; rx_c_rd_rdy = 1'b0; rx_h_resp_val = 1'b0; rx_c_resp_val = 1'b0;
    tx_h_rd_rdy = 1'b0; tx_t_rd_rdy = 1'b0; tx_h_resp_val = 1'b0; tx_t_resp_val = 1'b0;
    rx_wr_rdy = 1'b0; tx_wr_rdy = 1'b0; rd_req_rdy = 1'b0; rd_data_val = 1'b0;
    wr_req_rdy = 1'b0; wr_data_rdy = 1'b0; wr_done = 1'b0;
    hdr_arrived = 1'b0; rd_sat = 1'b0; wr_sat = 1'b0; last_wr = 1'b0;
    repeat (3) @(negedge clk);
    flowid_val = 1'b1; #1;
    chk("rst_yumi", 32'(yumi), 32'd0);
    chk("rst_all", 32'(any_out), 32'd0);
    flowid_val = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    chk("init_served", 32'(perf_served), 32'd0);
    chk("init_np", 32'(perf_np), 32'd0);
    chk("init_mode", 32'(sink_out), 32'd0);
    chk("init_idle", 32'(any_out), 32'd0);
    // Pointer responses offered while idle must not be accepted.
    rx_h_resp_val = 1'b1; rx_c_resp_val = 1'b1; tx_h_resp_val = 1'b1; tx_t_resp_val = 1'b1; #1;
    chk("late_rx_rdy", 32'(rx_h_resp_rdy | rx_c_resp_rdy), 32'd0);
    chk("late_tx_rdy", 32'(tx_h_resp_rdy | tx_t_resp_rdy), 32'd0);
    @(negedge clk);
    rx_h_resp_val = 1'b0; rx_c_resp_val = 1'b0; tx_h_resp_val = 1'b0; tx_t_resp_val = 1'b0; #1;

    run_flow(1'b0, 1'b1, 1'b1, 1'b1, 3, 0, 1'b0);
    run_flow(1'b1, 1'b1, 1'b1, 1'b1, 2, 0, 1'b0);
    run_flow(1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
    run_flow(1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
    run_flow(1'b1, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
    run_flow(1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
    run_flow(1'b0, 1'b1, 1'b1, 1'b1, 2, 3, 1'b0);
    run_flow(1'b1, 1'b1, 1'b1, 1'b1, 1, 3, 1'b0);
    repeat (12)
      run_flow(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               int'($urandom_range(1, 4)), int'($urandom_range(0, 2)), 1'b0);
    run_flow(1'b0, 1'b1, 1'b1, 1'b1, 2, 0, 1'b1);
    repeat (20)
      run_flow(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1,
               int'($urandom_range(1, 3)), int'($urandom_range(0, 1)), 1'b0);
    chk("served_saturated", 32'(perf_served), 32'(SATV));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
